// File: rtl/load_store_unit.sv
// Memory-access stage: issues one valid/ready data-memory transaction per load/store,
// aligns store lanes and extends load data. Optional misalignment trap: MISALIGN_CHECK_EN.
module load_store_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [DATA_WIDTH-1:0] ALUout,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  stall,
  output logic                  misalign,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [1:0]            r_state;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [1:0]            r_off;
  logic                  r_we;
  logic [3:0]            r_be;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [2:0]            r_funct3;
  logic [DATA_WIDTH-1:0] r_read_data;

  logic                  w_req;
  logic [1:0]            w_off;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_load_fmt;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic                  w_misaligned;

  assign w_req = MemRead | MemWrite;
  assign w_off = ALUout[1:0];

  // Store lane steering; B/BU and H/HU share a width, everything else is a word.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = WriteData;
    unique case (funct3)
      F3_B, F3_BU: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{WriteData[7:0]}};
      end
      F3_H, F3_HU: begin
        w_be    = w_off[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{WriteData[15:0]}};
      end
      default: ;
    endcase
    if (!MemWrite) w_be = 4'b1111;
  end

`ifdef MISALIGN_CHECK_EN
  always_comb begin
    w_misaligned = 1'b0;
    unique case (funct3)
      F3_B, F3_BU: w_misaligned = 1'b0;
      F3_H, F3_HU: w_misaligned = w_off[0];
      default:     w_misaligned = (w_off != 2'b00);
    endcase
  end
`else
  assign w_misaligned = 1'b0;
`endif

  // Load alignment uses the offset captured with the request, not the live address.
  always_comb begin
    w_byte     = mem_rdata[8*r_off +: 8];
    w_half     = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    w_load_fmt = mem_rdata;
    unique case (r_funct3)
      F3_B:    w_load_fmt = {{24{w_byte[7]}}, w_byte};
      F3_BU:   w_load_fmt = {24'h0, w_byte};
      F3_H:    w_load_fmt = {{16{w_half[15]}}, w_half};
      F3_HU:   w_load_fmt = {16'h0, w_half};
      default: w_load_fmt = mem_rdata;
    endcase
  end

`ifdef MISALIGN_CHECK_EN
  logic r_misalign;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_off       <= 2'b00;
      r_we        <= 1'b0;
      r_be        <= 4'b0000;
      r_wdata     <= '0;
      r_funct3    <= 3'b000;
      r_read_data <= '0;
`ifdef MISALIGN_CHECK_EN
      r_misalign  <= 1'b0;
`endif
    end else begin
`ifdef MISALIGN_CHECK_EN
      r_misalign <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_addr   <= {ALUout[DATA_WIDTH-1:2], 2'b00};
            r_off    <= w_off;
            r_we     <= MemWrite;
            r_be     <= w_be;
            r_wdata  <= w_wdata;
            r_funct3 <= funct3;
            if (w_misaligned) begin
              r_state <= DONE;
              if (!MemWrite) r_read_data <= '0;
`ifdef MISALIGN_CHECK_EN
              r_misalign <= 1'b1;
`endif
            end else begin
              r_state <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_ready) begin
            if (!r_we) r_read_data <= w_load_fmt;
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef MISALIGN_CHECK_EN
  assign misalign = r_misalign;
`else
  assign misalign = 1'b0;
`endif

  // Reset also masks the combinational IDLE stall so the core sees stall=0 at once.
  assign stall     = !rst && ((r_state == IDLE && w_req) || r_state == REQ);
  assign mem_req   = (r_state == REQ);
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_be    = r_be;
  assign mem_wdata = r_wdata;
  assign ReadData  = r_read_data;

endmodule

// File: tb/tb_load_store_unit.sv
// Table-driven bench for load_store_unit with a ReadData scoreboard and a
// mid-transaction reset sequence; honours MISALIGN_CHECK_EN like the design.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite;
  logic [31:0] ALUout, WriteData;
  logic [2:0]  funct3;
  logic [31:0] ReadData;
  logic        stall, misalign, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_ready;

`ifdef MISALIGN_CHECK_EN
  localparam bit MCHK = 1'b1;
`else
  localparam bit MCHK = 1'b0;
`endif

  load_store_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .ALUout(ALUout), .WriteData(WriteData), .funct3(funct3),
    .ReadData(ReadData), .stall(stall), .misalign(misalign),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rd;
    bit          mis;
  } vec_t;

  vec_t        vecs[14];
  logic [31:0] sb_q[$];
  logic [31:0] model_rd;
  int          n_vec  = 0;
  int          n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input bit st, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd, input int w,
                              input logic [31:0] ea, input logic [3:0] eb,
                              input logic [31:0] ewd, input logic [31:0] erd, input bit mis);
    vec_t v;
    v.store = st; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rd; v.waits = w;
    v.exp_addr = ea; v.exp_be = eb; v.exp_wdata = ewd; v.exp_rd = erd; v.mis = mis;
    return v;
  endfunction

  // Drive one memory instruction, play the memory side, and score the DONE cycle.
  task automatic run_vec(input vec_t v, input bit no_wait);
    int          stall_cycles = 0;
    int          req_cycles   = 0;
    bit          done         = 1'b0;
    bit          trap;
    logic [31:0] exp_rd;
    trap = MCHK && v.mis;
    if (!no_wait) @(negedge clk);
    MemRead   = !v.store;
    MemWrite  = v.store;
    ALUout    = v.addr;
    WriteData = v.wdata;
    funct3    = v.f3;
    mem_rdata = v.rdata;
    mem_ready = 1'b0;
    exp_rd    = v.store ? model_rd : (trap ? 32'h0 : v.exp_rd);
    sb_q.push_back(exp_rd);
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (stall) begin
        stall_cycles++;
        if (mem_req) begin
          req_cycles++;
          check("req_addr", mem_addr, v.exp_addr);
          check("req_be", {28'h0, mem_be}, {28'h0, v.exp_be});
          check("req_we", {31'h0, mem_we}, {31'h0, v.store});
          if (v.store) check("req_wdata", mem_wdata, v.exp_wdata);
          mem_ready = (req_cycles == v.waits + 1);
        end
        @(negedge clk);
      end else begin
        done = 1'b1;
        mem_ready = 1'b0;
        check("done_readdata", ReadData, sb_q.pop_front());
        check("done_mem_req", {31'h0, mem_req}, 32'h0);
        check("done_misalign", {31'h0, misalign}, {31'h0, trap});
        check("stall_cycles", stall_cycles, trap ? 1 : 2 + v.waits);
        check("req_cycles", req_cycles, trap ? 0 : v.waits + 1);
        if (!v.store) model_rd = exp_rd;
      end
    end
    if (!done) begin
      n_vec++;
      n_miss++;
      $display("FAIL timeout: stall never dropped for addr 0x%08h", v.addr);
      void'(sb_q.pop_front());
    end
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    @(negedge clk);
    #1;
    check("post_misalign", {31'h0, misalign}, 32'h0);
    check("post_stall", {31'h0, stall}, 32'h0);
  endtask

  initial begin
    vecs[0]  = mk(0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0, 32'h100, 4'hF, 32'h0,        32'hDEADBEEF, 0);
    vecs[1]  = mk(1, 3'b000, 32'h103, 32'h000000AB, 32'h0,        0, 32'h100, 4'h8, 32'hABABABAB, 32'h0,        0);
    vecs[2]  = mk(0, 3'b000, 32'h102, 32'h0,        32'h12803456, 0, 32'h100, 4'hF, 32'h0,        32'hFFFFFF80, 0);
    vecs[3]  = mk(0, 3'b100, 32'h102, 32'h0,        32'h12803456, 0, 32'h100, 4'hF, 32'h0,        32'h00000080, 0);
    vecs[4]  = mk(0, 3'b101, 32'h102, 32'h0,        32'h12803456, 0, 32'h100, 4'hF, 32'h0,        32'h00001280, 0);
    vecs[5]  = mk(0, 3'b001, 32'h100, 32'h0,        32'h00008001, 1, 32'h100, 4'hF, 32'h0,        32'hFFFF8001, 0);
    vecs[6]  = mk(1, 3'b001, 32'h106, 32'h12345678, 32'h0,        0, 32'h104, 4'hC, 32'h56785678, 32'h0,        0);
    vecs[7]  = mk(1, 3'b010, 32'h10C, 32'hCAFEF00D, 32'h0,        2, 32'h10C, 4'hF, 32'hCAFEF00D, 32'h0,        0);
    vecs[8]  = mk(0, 3'b010, 32'h200, 32'h0,        32'h01234567, 3, 32'h200, 4'hF, 32'h0,        32'h01234567, 0);
    vecs[9]  = mk(0, 3'b001, 32'h101, 32'h0,        32'hABCD7FFF, 0, 32'h100, 4'hF, 32'h0,        32'h00007FFF, 1);
    vecs[10] = mk(1, 3'b000, 32'h101, 32'hFFFFFF5A, 32'h0,        1, 32'h100, 4'h2, 32'h5A5A5A5A, 32'h0,        0);
    vecs[11] = mk(0, 3'b000, 32'h103, 32'h0,        32'h7F000000, 2, 32'h100, 4'hF, 32'h0,        32'h0000007F, 0);
    vecs[12] = mk(1, 3'b010, 32'h102, 32'h87654321, 32'h0,        0, 32'h100, 4'hF, 32'h87654321, 32'h0,        1);
    vecs[13] = mk(0, 3'b011, 32'h108, 32'h0,        32'h55AA55AA, 0, 32'h108, 4'hF, 32'h0,        32'h55AA55AA, 0);

    MemRead = 1'b0; MemWrite = 1'b0; ALUout = '0; WriteData = '0; funct3 = '0;
    mem_rdata = '0; mem_ready = 1'b0; model_rd = '0;
    #1 rst = 1'b1;
    #1;
    check("rst_readdata", ReadData, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_misalign", {31'h0, misalign}, 32'h0);
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_be", {28'h0, mem_be}, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // mem_ready outside REQ must not start or complete anything.
    mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      check("idle_ready_req", {31'h0, mem_req}, 32'h0);
      check("idle_ready_stall", {31'h0, stall}, 32'h0);
    end
    mem_ready = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(vecs[i], 1'b0);

    // Reset during the second REQ cycle, then restart with the request still held.
    @(negedge clk);
    MemRead = 1'b1; MemWrite = 1'b0; ALUout = 32'h300; funct3 = 3'b010;
    mem_rdata = 32'h0BADF00D; mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("pre_rst_req", {31'h0, mem_req}, 32'h1);
    rst = 1'b1;
    model_rd = 32'h0;
    #1;
    check("midrst_mem_req", {31'h0, mem_req}, 32'h0);
    check("midrst_stall", {31'h0, stall}, 32'h0);
    check("midrst_readdata", ReadData, model_rd);
    check("midrst_mem_be", {28'h0, mem_be}, 32'h0);
    check("midrst_mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(mk(0, 3'b010, 32'h300, 32'h0, 32'h0BADF00D, 1, 32'h300, 4'hF, 32'h0, 32'h0BADF00D, 0), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage that sits directly downstream of the ALU. It takes the ALU result as the effective address, together with store data and `funct3`, and issues a single valid/ready transaction to the data memory. Writes are byte-lane aligned, and load data is aligned and extended before it reaches writeback. While a transaction is outstanding it holds the core with `stall`.

## Interface
- `DATA_WIDTH`, 32: data and address width (the byte-lane logic is written for 32 only).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `MemRead`  in  1  current instruction is a load; held stable while `stall`=1.
- `MemWrite`  in  1  current instruction is a store; takes precedence if both are set.
- `ALUout`  in  32  effective address.
- `WriteData`  in  32  store data (rs2).
- `funct3`  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU. Other codes are treated as W.
- `ReadData`  out  32  registered, extended load result.
- `stall`  out  1  freeze PC and upstream stages.
- `misalign`  out  1  one-cycle pulse on a misaligned access (macro-dependent).
- `mem_req`  out  1  request valid.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  32  word address, `{ALUout[31:2],2'b00}`.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_rdata`  in  32  read word, valid when `mem_ready`=1.
- `mem_ready`  in  1  memory accepts/completes the request this cycle.

## Operation
- FSM states: IDLE, REQ, DONE.
- **IDLE**
  - If `MemRead|MemWrite`: `stall`=1 combinationally, latch address, `we`, `be`, `wdata` and `funct3`, then go to REQ.
  - Otherwise `stall`=0.
- **REQ**
  - `mem_req`=1 and `stall`=1.
  - All `mem_*` outputs come from registers and are stable until `mem_ready` is sampled high.
  - On `mem_ready`: for a load, register the formatted `mem_rdata` into `ReadData`; then go to DONE.
- **DONE**
  - `stall`=0 for exactly one cycle, so the core advances past the memory instruction.
  - Unconditional return to IDLE.
  - Request inputs are ignored in this state, which prevents re-issue of the same instruction.
- **Byte enables**
  - SB: `be` = `1<<addr[1:0]`, `wdata` = byte replicated ×4.
  - SH: `be` = 0011 (`addr[1]`=0) or 1100, `wdata` = half replicated ×2.
  - SW: `be` = 1111.
  - Loads: `mem_be`=1111.
- **Load format**
  - Byte/half is selected from `mem_rdata` by `addr[1:0]` / `addr[1]`.
  - B and H sign-extend; BU and HU zero-extend.
- **Hold rules**
  - Stores leave `ReadData` unchanged.
  - `mem_ready` is ignored outside REQ.
- **Reset** (async, any state, including mid-REQ)
  - FSM returns to IDLE, the transaction is abandoned, and `mem_req` drops immediately.
  - All outputs go to 0: `ReadData`=0, `stall`=0 (re-asserts combinationally in IDLE if a request is present), `misalign`=0, `mem_*`=0.

## Timing
- Cycle 0 (IDLE, request seen): `stall`=1.
- Cycle 1: first REQ cycle, `mem_req`=1.
- Completion: `mem_ready` sampled high in REQ cycle k (k≥1).
- Cycle k+1: DONE, with `ReadData` valid and `stall`=0.
- Minimum 3 cycles per memory instruction; each memory wait state adds one cycle.
- Non-memory instructions: zero added latency.

## Configuration
- `MISALIGN_CHECK_EN` defined:
  - A misaligned access (H with `addr[0]`=1, W with `addr[1:0]`≠0) issues no memory request and takes the path IDLE → DONE.
  - In DONE, `misalign`=1 and `ReadData`=0 for a load. No memory write occurs.
- `MISALIGN_CHECK_EN` not defined:
  - `misalign` is tied to 0.
  - H uses `addr[1]` only; W ignores `addr[1:0]`. Both proceed normally.

## Test plan
- LW at 0x100, `mem_ready` high on the first REQ cycle → `mem_addr`=0x100, `be`=1111, `stall` high for 2 cycles, DONE `ReadData`=`mem_rdata`=0xDEADBEEF.
- SB at 0x103 with `WriteData`=0x000000AB → `mem_we`=1, `be`=1000, `wdata`=0xABABABAB, `ReadData` unchanged.
- LB at 0x102 with `mem_rdata`=0x12803456 → `ReadData`=0xFFFFFF80; LBU at the same address → 0x00000080; LHU at 0x102 → 0x00001280.
- LW with `mem_ready` delayed 3 cycles → `mem_req` and `mem_addr` stable throughout, `stall` high for 5 cycles, one DONE cycle.
- With the macro, LH at 0x101 → `mem_req` never asserted, `misalign` pulses for 1 cycle, `ReadData`=0. Without the macro → request issued at 0x100 with `be`=1111, `misalign`=0.
- `rst` asserted in the second REQ cycle → `mem_req`, `stall` and `ReadData` are 0 immediately. After release with the request still present → the transaction restarts from IDLE.
